// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP -> IDLE. Arbitration is
// round-robin by default; define ALU_ARB_FIXED_PRIO_EN to give
// requester 0 fixed priority on ties.
//
//  state | meaning
//  ------+--------------------------------------------------------
//  IDLE  | no operation in flight; winner gets ready, fields latched
//  EXEC  | operand registers drive the ALU; result captured at edge
//  RESP  | result held on rsp{grant}; leaves on that rsp_ready

module alu_arbiter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic        i_req0_funct7,
   input  logic [2:0]  i_req0_op,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic        i_req1_funct7,
   input  logic [2:0]  i_req1_op,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   output logic        o_rsp0_valid,
   input  logic        i_rsp0_ready,
   output logic [31:0] o_rsp0_data,
   output logic        o_rsp1_valid,
   input  logic        i_rsp1_ready,
   output logic [31:0] o_rsp1_data,
   output logic        o_alu_funct7,
   output logic [2:0]  o_alu_op,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   input  logic [31:0] i_alu_data,
   output logic        o_busy,
   output logic        o_grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q;
   logic        funct7_q;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] result_q;
   logic        winner;
   logic        accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Tie goes to requester 0; a lone valid always wins.
   always_comb begin
      winner = i_req1_valid & ~i_req0_valid;
   end
`else
   logic prio_q;

   // Tie goes to the priority pointer; a lone valid always wins.
   always_comb begin
      if (i_req0_valid && i_req1_valid) winner = prio_q;
      else                              winner = i_req1_valid;
   end

   // Pointer moves past the requester just granted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       prio_q <= 1'b0;
      else if (accept) prio_q <= ~winner;
   end
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and request handshake; ready is masked during reset so
   // that every output reads 0 while i_rst is high.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if ((i_req0_valid || i_req1_valid) && !i_rst) begin
               accept       = 1'b1;
               o_req0_ready = ~winner;
               o_req1_ready = winner;
               state_d      = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (grant_q ? i_rsp1_ready : i_rsp0_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch on accept, result capture at the end of EXEC.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         grant_q  <= 1'b0;
         funct7_q <= 1'b0;
         op_q     <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
      end else if (accept) begin
         grant_q  <= winner;
         funct7_q <= winner ? i_req1_funct7 : i_req0_funct7;
         op_q     <= winner ? i_req1_op     : i_req0_op;
         a_q      <= winner ? i_req1_a      : i_req0_a;
         b_q      <= winner ? i_req1_b      : i_req0_b;
      end else if (state_q == EXEC) begin
         result_q <= i_alu_data;
      end
   end

   // Registered outputs; response valid is qualified by the grant.
   always_comb begin
      o_alu_funct7 = funct7_q;
      o_alu_op     = op_q;
      o_alu_a      = a_q;
      o_alu_b      = b_q;
      o_busy       = (state_q != IDLE);
      o_grant_id   = grant_q;
      o_rsp0_valid = (state_q == RESP) && !grant_q;
      o_rsp1_valid = (state_q == RESP) && grant_q;
      o_rsp0_data  = result_q;
      o_rsp1_data  = result_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of alu_arbiter with a behavioural ALU.
// Expected grants depend on ALU_ARB_FIXED_PRIO_EN.

module tb_alu_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req0_valid, i_req1_valid;
   logic        o_req0_ready, o_req1_ready;
   logic        i_req0_funct7, i_req1_funct7;
   logic [2:0]  i_req0_op, i_req1_op;
   logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
   logic        o_rsp0_valid, o_rsp1_valid;
   logic        i_rsp0_ready, i_rsp1_ready;
   logic [31:0] o_rsp0_data, o_rsp1_data;
   logic        o_alu_funct7;
   logic [2:0]  o_alu_op;
   logic [31:0] o_alu_a, o_alu_b;
   logic [31:0] i_alu_data;
   logic        o_busy, o_grant_id;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   // op 0: add (funct7=0) / sub (funct7=1); op 7: and; others: xor
   assign i_alu_data = (o_alu_op == 3'd0) ? (o_alu_funct7 ? o_alu_a - o_alu_b : o_alu_a + o_alu_b)
                     : (o_alu_op == 3'd7) ? (o_alu_a & o_alu_b) : (o_alu_a ^ o_alu_b);

   alu_arbiter dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_funct7(i_req0_funct7), .i_req0_op(i_req0_op),
      .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_funct7(i_req1_funct7), .i_req1_op(i_req1_op),
      .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
      .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_data(o_rsp0_data),
      .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_data(o_rsp1_data),
      .o_alu_funct7(o_alu_funct7), .o_alu_op(o_alu_op),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .i_alu_data(i_alu_data),
      .o_busy(o_busy), .o_grant_id(o_grant_id)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic        exp_w;
   logic [31:0] exp_d;

   initial begin
      i_rst = 1'b1;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      i_req0_funct7 = 1'b0; i_req0_op = 3'd0; i_req0_a = 32'd5; i_req0_b = 32'd3;
      i_req1_funct7 = 1'b0; i_req1_op = 3'd0; i_req1_a = 32'd0; i_req1_b = 32'd0;
      i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;

      // Reset: all outputs 0 even with valids high
      tick(); tick();
      chk("rst_ready0", {31'd0, o_req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, o_req1_ready}, 32'd0);
      chk("rst_busy",   {31'd0, o_busy}, 32'd0);
      chk("rst_grant",  {31'd0, o_grant_id}, 32'd0);
      chk("rst_rspv",   {30'd0, o_rsp1_valid, o_rsp0_valid}, 32'd0);
      chk("rst_alu_a",  o_alu_a, 32'd0);
      chk("rst_data",   o_rsp0_data, 32'd0);

      // Single request from req0: 5+3, rsp at T+2
      i_req1_valid = 1'b0;
      i_rst = 1'b0;
      #1;
      chk("single_ready0", {31'd0, o_req0_ready}, 32'd1);
      chk("single_ready1", {31'd0, o_req1_ready}, 32'd0);
      tick();
      i_req0_valid = 1'b0;
      #1;
      chk("single_exec_busy",  {31'd0, o_busy}, 32'd1);
      chk("single_exec_ready", {31'd0, o_req0_ready}, 32'd0);
      chk("single_exec_alu_a", o_alu_a, 32'd5);
      chk("single_exec_rspv",  {31'd0, o_rsp0_valid}, 32'd0);
      tick();
      chk("single_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd1);
      chk("single_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd0);
      chk("single_rsp0_data",  o_rsp0_data, 32'd8);
      tick();
      chk("single_idle_busy",  {31'd0, o_busy}, 32'd0);
      chk("single_idle_rspv",  {31'd0, o_rsp0_valid}, 32'd0);

      // Fresh reset so the pointer starts at 0, then both held valid
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_req0_valid = 1'b1; i_req0_funct7 = 1'b0; i_req0_a = 32'd10; i_req0_b = 32'd1;
      i_req1_valid = 1'b1; i_req1_funct7 = 1'b1; i_req1_a = 32'd20; i_req1_b = 32'd2;
      #1;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_w = 1'b0;
`else
         exp_w = k[0];
`endif
         exp_d = exp_w ? 32'd18 : 32'd11;
         chk($sformatf("both%0d_ready0", k), {31'd0, o_req0_ready}, {31'd0, ~exp_w});
         chk($sformatf("both%0d_ready1", k), {31'd0, o_req1_ready}, {31'd0, exp_w});
         tick();
         chk($sformatf("both%0d_grant", k), {31'd0, o_grant_id}, {31'd0, exp_w});
         tick();
         chk($sformatf("both%0d_rspv", k), {30'd0, o_rsp1_valid, o_rsp0_valid},
             exp_w ? 32'd2 : 32'd1);
         chk($sformatf("both%0d_data", k), exp_w ? o_rsp1_data : o_rsp0_data, exp_d);
         tick();
      end

      // Stalled response on req0 while req1 waits (pointer is 0 in both builds)
      i_req0_a = 32'd7;   i_req0_b = 32'd9;
      i_req1_a = 32'd100; i_req1_b = 32'd1;
      i_rsp0_ready = 1'b0;
      #1;
      chk("stall_ready0", {31'd0, o_req0_ready}, 32'd1);
      chk("stall_ready1", {31'd0, o_req1_ready}, 32'd0);
      tick();
      i_req0_valid = 1'b0;
      #1;
      chk("stall_exec_ready1", {31'd0, o_req1_ready}, 32'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d_rsp0_valid", k), {31'd0, o_rsp0_valid}, 32'd1);
         chk($sformatf("stall%0d_rsp0_data", k), o_rsp0_data, 32'd16);
         chk($sformatf("stall%0d_ready1", k), {31'd0, o_req1_ready}, 32'd0);
         tick();
      end
      i_rsp0_ready = 1'b1;
      #1;
      chk("stall_hs_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd1);
      chk("stall_hs_ready1", {31'd0, o_req1_ready}, 32'd0);
      tick();
      chk("stall_after_ready1", {31'd0, o_req1_ready}, 32'd1);
      chk("stall_after_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd0);
      tick();
      i_req1_valid = 1'b0;
      #1;
      chk("stall_r1_grant", {31'd0, o_grant_id}, 32'd1);
      tick();
      chk("stall_r1_rspv", {30'd0, o_rsp1_valid, o_rsp0_valid}, 32'd2);
      chk("stall_r1_data", o_rsp1_data, 32'd99);
      tick();

      // Reset during EXEC discards the operation and clears the pointer
      i_req0_valid = 1'b1; i_req0_funct7 = 1'b0; i_req0_a = 32'h1234; i_req0_b = 32'd1;
      #1;
      chk("rex_ready0", {31'd0, o_req0_ready}, 32'd1);
      tick();
      i_req0_valid = 1'b0;
      #1;
      chk("rex_exec_alu_a", o_alu_a, 32'h1234);
      chk("rex_exec_busy", {31'd0, o_busy}, 32'd1);
      i_rst = 1'b1;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      #1;
      chk("rex_busy",   {31'd0, o_busy}, 32'd0);
      chk("rex_alu_a",  o_alu_a, 32'd0);
      chk("rex_alu_b",  o_alu_b, 32'd0);
      chk("rex_data",   o_rsp0_data, 32'd0);
      chk("rex_ready",  {30'd0, o_req1_ready, o_req0_ready}, 32'd0);
      chk("rex_rspv",   {30'd0, o_rsp1_valid, o_rsp0_valid}, 32'd0);
      tick();
      chk("rex_hold_rspv", {30'd0, o_rsp1_valid, o_rsp0_valid}, 32'd0);
      i_req0_a = 32'd3; i_req0_b = 32'd4;
      i_rst = 1'b0;
      #1;
      chk("post_rst_ready0", {31'd0, o_req0_ready}, 32'd1);
      chk("post_rst_ready1", {31'd0, o_req1_ready}, 32'd0);
      tick();
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      #1;
      chk("post_rst_grant", {31'd0, o_grant_id}, 32'd0);
      tick();
      chk("post_rst_rspv", {30'd0, o_rsp1_valid, o_rsp0_valid}, 32'd1);
      chk("post_rst_data", o_rsp0_data, 32'd7);
      tick();
      chk("post_rst_idle", {31'd0, o_busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have, for n = 0,1, port i_req{n}_valid, input, 1, requester n has an operation pending.
REQ-004 SHALL have, for n = 0,1, port o_req{n}_ready, output, 1, request n accepted this cycle.
REQ-005 SHALL have, for n = 0,1, ports i_req{n}_funct7 (input, 1), i_req{n}_op (input, 3), i_req{n}_a (input, 32) and i_req{n}_b (input, 32), carrying operation fields.
REQ-006 SHALL have, for n = 0,1, port o_rsp{n}_valid, output, 1, result for requester n available.
REQ-007 SHALL have, for n = 0,1, port i_rsp{n}_ready, input, 1, requester n consumes result.
REQ-008 SHALL have, for n = 0,1, port o_rsp{n}_data, output, 32, result value.
REQ-009 SHALL have ports o_alu_funct7 (output, 1), o_alu_op (output, 3), o_alu_a (output, 32) and o_alu_b (output, 32), driving the shared combinational ALU.
REQ-010 SHALL have port i_alu_data, input, 32, combinational ALU result.
REQ-011 SHALL have port o_busy, output, 1, FSM not in IDLE.
REQ-012 SHALL have port o_grant_id, output, 1, requester currently owning the ALU.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-014 IDLE: SHALL assert o_req{w}_ready combinationally for winner w only, when at least one valid is high; on that edge SHALL latch w's fields into operand registers, set o_grant_id=w and go to EXEC.
REQ-015 IDLE with no valid: SHALL stay in IDLE with no ready asserted.
REQ-016 SHALL drive o_alu_* from the operand registers in all states.
REQ-017 EXEC: SHALL capture i_alu_data into the result register at the edge and go to RESP (exactly one cycle).
REQ-018 RESP: SHALL hold o_rsp{g}_valid=1 with stable o_rsp{g}_data for g=o_grant_id; on the edge where i_rsp{g}_ready=1, SHALL go to IDLE.
REQ-019 o_rsp{other}_valid SHALL be 0 at all times other than that requester's own RESP.
REQ-020 Latency: request accepted at cycle T, SHALL give rsp_valid first at T+2; throughput SHALL be at most one operation per 3 cycles.
REQ-021 No o_req ready SHALL be asserted outside IDLE; valids arriving in EXEC/RESP SHALL wait.
REQ-022 Round-robin: priority pointer p SHALL start at 0; on a tie, requester p SHALL win; after each grant, p SHALL be set to (w+1) mod 2.
REQ-023 Single valid: that requester SHALL win regardless of p.
REQ-024 o_rsp{n}_data SHALL equal the result register for both n; only valid qualifies it.

Reset
REQ-025 Assertion of i_rst, at any time including mid-EXEC/RESP, SHALL immediately force IDLE and clear p, o_grant_id, operand registers and the result register to 0.
REQ-026 Assertion of i_rst SHALL discard any in-flight operation without producing a response.
REQ-027 While i_rst is high, all outputs SHALL be 0.

Configuration
REQ-028 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and p SHALL be unused (held at 0).
REQ-029 Without ALU_ARB_FIXED_PRIO_EN defined, round-robin per REQ-022 SHALL apply.

Verification
REQ-030 Only req0 valid, op=0, funct7=0, a=5, b=3, model returns a+b -> ready0 at T, rsp0_valid at T+2, data=8.
REQ-031 Both valid at T0 (round-robin build), then held -> grants 0,1,0,1 alternate; responses go only to the granted requester.
REQ-032 Both valid, ALU_ARB_FIXED_PRIO_EN defined -> req0 granted every time; req1 starves while req0 is held valid.
REQ-033 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and data stay stable; req1 is not granted until the cycle after the handshake.
REQ-034 i_rst pulsed during EXEC -> outputs 0 immediately; no rsp_valid; next request after release is served normally with p=0.
